// File: rtl/mem_ctrl_pkg.sv
// Shared constants, opcode encodings and FSM state type for the data-memory access controller.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 6;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_COPY  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StFill,
        StCpRd,
        StCpWr,
        StDone
    } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for a 32x16 single-port data memory. Accepts LOAD, STORE,
// FILL and COPY requests over valid/ready and drives registered addr/data/wr_en pins.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LEN_W-1:0]  len,
    output logic              resp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_q
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;

    logic accept;
    logic last_word;

    assign accept    = req_valid && (state_q == StIdle);
    assign last_word = (count_q == '0);

    // State register and all registered outputs; reset drops mem_wr_en immediately.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= StIdle;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_wr_en_q  <= 1'b0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            count_q      <= '0;
            src_q        <= '0;
            dst_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_wr_en_q  <= mem_wr_en_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            count_q      <= count_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    unique case (op)
                        OP_LOAD:  state_d = StRd;
                        OP_STORE: state_d = StWr;
                        OP_FILL:  state_d = (len == '0) ? StDone : StFill;
                        OP_COPY:  state_d = (len == '0) ? StDone : StCpRd;
                        default:  state_d = StIdle;
                    endcase
                end
            end
            StRd, StWr, StDone: state_d = StIdle;
            StFill:             state_d = last_word ? StIdle : StFill;
            StCpRd:             state_d = StCpWr;
            StCpWr:             state_d = last_word ? StIdle : StCpRd;
            default:            state_d = StIdle;
        endcase
    end

    // Next values for the memory-side pins, counters and response registers.
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_wr_en_d  = mem_wr_en_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        count_d      = count_q;
        src_d        = src_q;
        dst_d        = dst_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mem_addr_d  = addr_a;
                    src_d       = addr_a;
                    dst_d       = addr_b;
                    count_d     = len - LEN_W'(1);
                    mem_wr_en_d = 1'b0;
                    // STORE and non-empty FILL start writing on the very next edge.
                    if (op == OP_STORE || (op == OP_FILL && len != '0)) begin
                        mem_data_d  = wdata;
                        mem_wr_en_d = 1'b1;
                    end
                end
            end
            StRd: begin
                rdata_d      = mem_q;
                resp_valid_d = 1'b1;
            end
            StWr: begin
                mem_wr_en_d  = 1'b0;
                resp_valid_d = 1'b1;
            end
            StFill: begin
                if (last_word) begin
                    mem_wr_en_d  = 1'b0;
                    resp_valid_d = 1'b1;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    count_d    = count_q - LEN_W'(1);
                end
            end
            StCpRd: begin
                mem_data_d  = mem_q;
                mem_addr_d  = dst_q;
                mem_wr_en_d = 1'b1;
            end
            StCpWr: begin
                mem_wr_en_d = 1'b0;
                if (last_word) begin
                    resp_valid_d = 1'b1;
                end else begin
                    // Ascending one word at a time gives forward-copy semantics on overlap.
                    src_d      = src_q + ADDR_W'(1);
                    dst_d      = dst_q + ADDR_W'(1);
                    count_d    = count_q - LEN_W'(1);
                    mem_addr_d = src_q + ADDR_W'(1);
                end
            end
            StDone: begin
                resp_valid_d = 1'b1;
            end
            default: begin
                mem_wr_en_d = 1'b0;
            end
        endcase
    end

    // Output drive from registers.
    always_comb begin
        req_ready  = (state_q == StIdle);
        busy       = (state_q != StIdle);
        resp_valid = resp_valid_q;
        rdata      = rdata_q;
        mem_addr   = mem_addr_q;
        mem_data   = mem_data_q;
        mem_wr_en  = mem_wr_en_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural 32x16 memory attached.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic              Clock = 1'b0;
    logic              Resetn = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        op = '0;
    logic [ADDR_W-1:0] addr_a = '0;
    logic [ADDR_W-1:0] addr_b = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              resp_valid;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_q;

    mem_access_ctrl dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .wdata      (wdata),
        .len        (len),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wr_en  (mem_wr_en),
        .mem_q      (mem_q)
    );

    always #5 Clock = ~Clock;

    // Memory under control: combinational read, write on rising edge.
    logic [DATA_W-1:0] mem [32];
    assign mem_q = mem[mem_addr];
    always @(posedge Clock) if (mem_wr_en) mem[mem_addr] <= mem_data;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        string             name;
        logic [DATA_W-1:0] rdata;
        int                lat;
        int                accept;
        int                writes;
        logic [511:0]      snap;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] ref_mem [32];
    logic [DATA_W-1:0] exp_rdata = '0;
    int                checks = 0;
    int                errors = 0;
    int                wr_count = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [511:0] pack_ref();
        logic [511:0] s;
        for (int i = 0; i < 32; i++) s[i*16 +: 16] = ref_mem[i];
        return s;
    endfunction

    // Reference model: applies a whole request to ref_mem at once and queues the outcome.
    task automatic model(input logic [1:0] o, input int a, input int b, input logic [15:0] wd,
                         input int ln, input int acc);
        exp_t e;
        e.accept = acc;
        unique case (o)
            OP_LOAD: begin
                exp_rdata = ref_mem[a];
                e.name = "load"; e.lat = 1; e.writes = 0;
            end
            OP_STORE: begin
                ref_mem[a] = wd;
                e.name = "store"; e.lat = 1; e.writes = 1;
            end
            OP_FILL: begin
                for (int k = 0; k < ln; k++) ref_mem[(a + k) % 32] = wd;
                e.name = "fill"; e.lat = (ln == 0) ? 1 : ln; e.writes = ln;
            end
            default: begin
                for (int k = 0; k < ln; k++) ref_mem[(b + k) % 32] = ref_mem[(a + k) % 32];
                e.name = "copy"; e.lat = (ln == 0) ? 1 : 2 * ln; e.writes = ln;
            end
        endcase
        e.rdata = exp_rdata;
        e.snap  = pack_ref();
        sb.push_back(e);
    endtask

    // Present a request and leave req_valid high; returns just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [4:0] a, input logic [4:0] b,
                         input logic [15:0] wd, input logic [5:0] ln, input bit track);
        int guard = 0;
        @(negedge Clock);
        op = o; addr_a = a; addr_b = b; wdata = wd; len = ln; req_valid = 1'b1;
        while (!req_ready && guard < 400) begin
            @(negedge Clock);
            guard++;
        end
        chk("accept_within_bound", {31'd0, req_ready}, 32'd1);
        if (track) model(o, int'(a), int'(b), wd, int'(ln), cyc + 1);
        @(posedge Clock);
    endtask

    task automatic drain();
        int guard = 0;
        @(negedge Clock);
        req_valid = 1'b0;
        while (sb.size() != 0 && guard < 3000) begin
            @(negedge Clock);
            guard++;
        end
        chk("drain_scoreboard_empty", sb.size(), 0);
    endtask

    // Monitor: pops an expectation on each response pulse and checks it.
    always @(negedge Clock) begin
        if (!Resetn) begin
            wr_count = 0;
        end else begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    int bad;
                    e = sb.pop_front();
                    bad = 0;
                    chk({e.name, "_latency"}, cyc - e.accept, e.lat);
                    chk({e.name, "_rdata"}, {16'd0, rdata}, {16'd0, e.rdata});
                    chk({e.name, "_write_cycles"}, wr_count, e.writes);
                    for (int i = 0; i < 32; i++) if (mem[i] !== e.snap[i*16 +: 16]) bad++;
                    chk({e.name, "_mem_words_wrong"}, bad, 0);
                end
                wr_count = 0;
            end
            if (mem_wr_en) wr_count++;
            if (busy === req_ready) chk("busy_is_not_ready", {31'd0, busy}, {31'd0, ~req_ready});
        end
    end

    initial begin
        logic [15:0] v;
        logic [1:0]  ro;
        logic [4:0]  ra, rb;
        logic [5:0]  rl;
        int          bad;

        for (int i = 0; i < 32; i++) begin
            v = 16'($urandom);
            if (i == 0) v = 16'h2011;
            mem[i] <= v;
            ref_mem[i] = v;
        end

        #1 Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        chk("reset_mem_addr", {27'd0, mem_addr}, 32'd0);
        chk("reset_mem_data", {16'd0, mem_data}, 32'd0);
        chk("reset_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("reset_rdata", {16'd0, rdata}, 32'd0);
        chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        Resetn = 1'b1;
        @(negedge Clock);
        chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        // Directed cases.
        issue(OP_LOAD, 5'd0, 5'd0, 16'h0, 6'd0, 1'b1);
        issue(OP_STORE, 5'd7, 5'd0, 16'hBEEF, 6'd0, 1'b1);
        issue(OP_LOAD, 5'd7, 5'd0, 16'h0, 6'd0, 1'b1);
        issue(OP_FILL, 5'd30, 5'd0, 16'h00A5, 6'd4, 1'b1);
        issue(OP_STORE, 5'd0, 5'd0, 16'd1, 6'd0, 1'b1);
        issue(OP_STORE, 5'd1, 5'd0, 16'd2, 6'd0, 1'b1);
        issue(OP_STORE, 5'd2, 5'd0, 16'd3, 6'd0, 1'b1);
        issue(OP_COPY, 5'd0, 5'd10, 16'h0, 6'd3, 1'b1);
        issue(OP_STORE, 5'd4, 5'd0, 16'd9, 6'd0, 1'b1);
        issue(OP_COPY, 5'd4, 5'd5, 16'h0, 6'd3, 1'b1);
        issue(OP_LOAD, 5'd7, 5'd0, 16'h0, 6'd0, 1'b1);
        issue(OP_FILL, 5'd3, 5'd0, 16'h7777, 6'd0, 1'b1);
        issue(OP_COPY, 5'd1, 5'd20, 16'h0, 6'd0, 1'b1);
        issue(OP_COPY, 5'd28, 5'd30, 16'h0, 6'd40, 1'b1);

        // Randomized traffic; req_valid stays high while the controller is busy.
        for (int n = 0; n < 120; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 5'($urandom);
            rb = 5'($urandom);
            v  = 16'($urandom);
            rl = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 5));
            issue(ro, ra, rb, v, rl, 1'b1);
        end
        drain();

        // Reset in the middle of an 8-word FILL, after three words have been written.
        issue(OP_FILL, 5'd8, 5'd0, 16'hC3C3, 6'd8, 1'b0);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge Clock);
        #2 Resetn = 1'b0;
        #1 chk("midreset_wr_en_drops", {31'd0, mem_wr_en}, 32'd0);
        chk("midreset_no_resp", {31'd0, resp_valid}, 32'd0);
        for (int k = 0; k < 3; k++) ref_mem[8 + k] = 16'hC3C3;
        exp_rdata = '0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        chk("midreset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midreset_rdata_cleared", {16'd0, rdata}, 32'd0);
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("midreset_mem_words_wrong", bad, 0);
        issue(OP_LOAD, 5'd10, 5'd0, 16'h0, 6'd0, 1'b1);
        issue(OP_LOAD, 5'd11, 5'd0, 16'h0, 6'd0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
